// File: rtl/exec_sequencer.sv
// Run-control sequencer: turns button pulses into load/exec/pc strobes for the MIPS board.
// Optional retired-instruction counter is built only when EXEC_SEQ_ICOUNT_EN is defined.
module exec_sequencer #(
  parameter int RUN_GAP = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_fpga,
  input  logic             req_step,
  input  logic             req_run,
  input  logic             halt,
  output logic             load_fpga,
  output logic             load_imem,
  output logic             exec_en,
  output logic             pc_inc,
  output logic             busy,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  localparam int GAP_W = (RUN_GAP > 1) ? $clog2(RUN_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADF,
    S_LOADI,
    S_EXECF,
    S_EXECI,
    S_GAP,
    S_HALTED
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_running;
  logic             w_set_run;
  logic             w_clr_run;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_running <= 1'b0;
    end else begin
      r_state <= w_next;
      // The gap counter is loaded as GAP is entered so it reads RUN_GAP-1 in the first gap cycle.
      if (w_next == S_GAP && r_state != S_GAP) begin
        r_gap_cnt <= GAP_W'(RUN_GAP - 1);
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
      if (w_clr_run) begin
        r_running <= 1'b0;
      end else if (w_set_run) begin
        r_running <= 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_set_run = 1'b0;
    w_clr_run = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (halt) begin
          w_next    = S_HALTED;
          w_clr_run = 1'b1;
        end else if (req_fpga) begin
          w_next = S_LOADF;
        end else if (req_step) begin
          w_next = S_LOADI;
        end else if (req_run) begin
          w_next    = S_LOADI;
          w_set_run = 1'b1;
        end
      end
      S_LOADF: begin
        if (halt) begin
          w_next    = S_HALTED;
          w_clr_run = 1'b1;
        end else begin
          w_next = S_EXECF;
        end
      end
      S_LOADI: begin
        if (halt) begin
          w_next    = S_HALTED;
          w_clr_run = 1'b1;
        end else begin
          w_next = S_EXECI;
        end
      end
      S_EXECF: w_next = S_IDLE;
      S_EXECI: w_next = r_running ? S_GAP : S_IDLE;
      S_GAP: begin
        // halt outranks a stop request, which outranks the end of the gap.
        if (halt) begin
          w_next    = S_HALTED;
          w_clr_run = 1'b1;
        end else if (req_run) begin
          w_next    = S_IDLE;
          w_clr_run = 1'b1;
        end else if (r_gap_cnt == '0) begin
          w_next = S_LOADI;
        end
      end
      S_HALTED: begin
        w_next    = S_HALTED;
        w_clr_run = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign load_fpga = (r_state == S_LOADF);
  assign load_imem = (r_state == S_LOADI);
  assign exec_en   = (r_state == S_EXECF) || (r_state == S_EXECI);
  assign pc_inc    = (r_state == S_EXECI);
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted    = (r_state == S_HALTED);
  assign running   = r_running;

`ifdef EXEC_SEQ_ICOUNT_EN
  logic [CNT_W-1:0] r_icount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_icount <= '0;
    end else if (exec_en) begin
      r_icount <= r_icount + CNT_W'(1);
    end
  end

  assign icount = r_icount;
`else
  assign icount = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: expected strobes are queued when requests are driven
// and compared as the DUT emits them; icount expectation follows EXEC_SEQ_ICOUNT_EN.
module tb_exec_sequencer;

  localparam int RUN_GAP = 4;
  localparam int CNT_W   = 4;

  typedef struct {
    int         cyc;
    logic [3:0] val;  // {load_fpga, load_imem, exec_en, pc_inc}
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_fpga = 1'b0;
  logic req_step = 1'b0;
  logic req_run = 1'b0;
  logic halt = 1'b0;
  logic load_fpga, load_imem, exec_en, pc_inc, busy, running, halted;
  logic [CNT_W-1:0] icount;

  int   cyc = 0;
  int   t0 = 0;
  int   n_total = 0;
  int   n_bad = 0;
  int   exp_icnt = 0;
  exp_t sb[$];

  exec_sequencer #(.RUN_GAP(RUN_GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_fpga(req_fpga), .req_step(req_step), .req_run(req_run),
    .halt(halt), .load_fpga(load_fpga), .load_imem(load_imem), .exec_en(exec_en),
    .pc_inc(pc_inc), .busy(busy), .running(running), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_ic();
`ifdef EXEC_SEQ_ICOUNT_EN
    return 32'(exp_icnt % 16);
`else
    return 32'd0;
`endif
  endfunction

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
    if (v[1]) exp_icnt++;
  endtask

  // Requests are raised at a falling edge and sampled at the next rising edge (t0+1).
  task automatic req_pulse(input logic f, input logic s, input logic r);
    @(negedge clk);
    req_fpga = f;
    req_step = s;
    req_run  = r;
    t0 = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(negedge clk);
      req_fpga = 1'b0;
      req_step = 1'b0;
      req_run  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    halt = 1'b0;
    req_fpga = 1'b0;
    req_step = 1'b0;
    req_run = 1'b0;
    exp_icnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [3:0] got;
    exp_t e;
    got = {load_fpga, load_imem, exec_en, pc_inc};
    if (!reset && got != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(got), 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_value", 32'(got), 32'(e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    #12;
    check("rst_strobes", 32'({load_fpga, load_imem, exec_en, pc_inc}), 32'd0);
    check("rst_flags", 32'({busy, running, halted}), 32'd0);
    check("rst_icount", 32'(icount), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single step sampled around cycle 10.
    wait_until(9);
    req_pulse(1'b0, 1'b1, 1'b0);
    push(t0 + 1, 4'b0100);
    push(t0 + 2, 4'b0011);
    wait_until(t0 + 1);
    check("step_busy", 32'(busy), 32'd1);
    wait_until(t0 + 3);
    check("step_idle", 32'(busy), 32'd0);
    check("step_icount", 32'(icount), exp_ic());
    check("step_drain", sb.size(), 0);

    // Switch and step together: switch wins, no pc_inc.
    req_pulse(1'b1, 1'b1, 1'b0);
    push(t0 + 1, 4'b1000);
    push(t0 + 2, 4'b0010);
    wait_until(t0 + 1);
    req_pulse(1'b0, 1'b1, 1'b0);  // lands in EXECF and is dropped
    wait_until(t0 + 4);
    check("fs_drain", sb.size(), 0);
    check("fs_icount", 32'(icount), exp_ic());

    // Free-run: exec every 2+RUN_GAP cycles, then stop during GAP.
    req_pulse(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      push(t0 + 1 + k * (2 + RUN_GAP), 4'b0100);
      push(t0 + 2 + k * (2 + RUN_GAP), 4'b0011);
    end
    wait_until(t0 + 3);
    check("run_flag", 32'(running), 32'd1);
    wait_until(t0 + 15);
    req_pulse(1'b0, 1'b0, 1'b1);
    wait_until(t0 + 12);
    check("run_stopped", 32'(running), 32'd0);
    check("run_idle", 32'(busy), 32'd0);
    check("run_drain", sb.size(), 0);
    check("run_icount", 32'(icount), exp_ic());

    // Halt during GAP is sticky and ignores requests.
    req_pulse(1'b0, 1'b0, 1'b1);
    push(t0 + 1, 4'b0100);
    push(t0 + 2, 4'b0011);
    wait_until(t0 + 3);
    halt = 1'b1;
    wait_until(t0 + 5);
    halt = 1'b0;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_running", 32'(running), 32'd0);
    check("halt_busy", 32'(busy), 32'd0);
    req_pulse(1'b1, 1'b1, 1'b1);
    wait_until(t0 + 2);
    req_pulse(1'b0, 1'b1, 1'b0);
    wait_until(t0 + 6);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_drain", sb.size(), 0);

    // halt with a request in IDLE goes straight to HALTED.
    do_reset();
    check("rst2_halted", 32'(halted), 32'd0);
    halt = 1'b1;
    req_pulse(1'b0, 1'b1, 1'b0);
    wait_until(t0 + 3);
    halt = 1'b0;
    check("idle_halt", 32'(halted), 32'd1);
    check("idle_halt_drain", sb.size(), 0);

    // Reset during LOADI aborts without an exec.
    do_reset();
    req_pulse(1'b0, 1'b1, 1'b0);
    push(t0 + 1, 4'b0100);
    exp_icnt = 0;
    wait_until(t0 + 1);
    #2 reset = 1'b1;
    #1;
    check("abort_strobes", 32'({load_fpga, load_imem, exec_en, pc_inc}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_until(cyc + 4);
    check("abort_drain", sb.size(), 0);
    check("abort_icount", 32'(icount), 32'd0);
    req_pulse(1'b0, 1'b1, 1'b0);
    push(t0 + 1, 4'b0100);
    push(t0 + 2, 4'b0011);
    wait_until(t0 + 3);
    check("post_abort_drain", sb.size(), 0);

    // 17 steps from zero wrap a 4-bit counter to 1.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      req_pulse(1'b0, 1'b1, 1'b0);
      push(t0 + 1, 4'b0100);
      push(t0 + 2, 4'b0011);
      wait_until(t0 + 3);
    end
    check("wrap_icount", 32'(icount), exp_ic());
    check("wrap_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Run-control sequencer for the single-cycle MIPS board build. Turns debounced button pulses into the per-instruction strobes that drive the instruction selector and datapath: load a switch-entered instruction, or load the next instruction-memory word, then commit it and advance the PC. Supports single-step and free-run modes, and stops permanently on `halt`.

## Interface
- `RUN_GAP`, 4: idle cycles between instructions in run mode, minimum 1.
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_fpga`  in  1  one-cycle pulse: execute the switch instruction once.
- `req_step`  in  1  one-cycle pulse: execute the next imem instruction once.
- `req_run`  in  1  one-cycle pulse: toggles free-run mode.
- `halt`  in  1  level from datapath: halt instruction decoded.
- `load_fpga`  out  1  one-cycle strobe to selector: latch switch instruction.
- `load_imem`  out  1  one-cycle strobe to selector: latch imem instruction.
- `exec_en`  out  1  one-cycle commit strobe (register file/memory write enable gate).
- `pc_inc`  out  1  one-cycle PC advance strobe.
- `busy`  out  1  high whenever state is not IDLE or HALTED.
- `running`  out  1  free-run mode flag.
- `halted`  out  1  high in HALTED.
- `icount`  out  CNT_W  retired-instruction count.

## Operation
- Moore FSM with states IDLE, LOADF, LOADI, EXECF, EXECI, GAP, HALTED. All strobes are decoded from state only.
- `load_fpga`=LOADF, `load_imem`=LOADI, `exec_en`=EXECF|EXECI, and `pc_inc`=EXECI.
- Switch instructions never advance the PC.
- IDLE priority: `halt` first, to HALTED. Then `req_fpga` to LOADF, `req_step` to LOADI, and `req_run` sets `running` and goes to LOADI.
- LOADF goes to EXECF, and LOADI goes to EXECI. If `halt` is high in a LOAD state, go to HALTED with no exec.
- EXECF always goes to IDLE.
- EXECI goes to GAP if `running`, otherwise to IDLE.
- GAP loads the gap counter with RUN_GAP-1 on entry and decrements it each cycle.
  - At 0, go to LOADI.
  - `halt` in GAP goes to HALTED.
  - `req_run` in GAP clears `running` and goes to IDLE.
- Requests in LOADx/EXECx are dropped, not queued.
- `req_run` is honoured only in IDLE and GAP.
- HALTED is sticky until `reset`. It clears `running` and ignores all requests.
- `icount` increments by 1 on every `exec_en` cycle and wraps from all-ones to 0.

## Timing
- Reset (async): state IDLE. All strobes 0; `busy`=0, `running`=0, `halted`=0, `icount`=0.
- Reset mid-operation aborts immediately. No strobe is emitted afterwards.
- Step (request sampled at edge N):
  - `load_imem` high in cycle N+1.
  - `exec_en` and `pc_inc` high in cycle N+2.
  - Back in IDLE at N+3.
  - The selector output is valid during the exec cycle.
- Switch instruction: `load_fpga` in N+1, `exec_en` in N+2, `pc_inc` stays 0.
- Run mode: instruction period is 2+RUN_GAP cycles; with the default, `exec_en` fires every 6 cycles.
- Simultaneous `req_fpga`+`req_step` in IDLE: only the switch instruction executes.
- `halt` and a request in the same IDLE cycle: go to HALTED.
- At most one strobe of `load_fpga`/`load_imem` per cycle. They are never high together with `exec_en`.

## Configuration
- `EXEC_SEQ_ICOUNT_EN` defined: `icount` counts as above.
- Undefined: the counter is not built and `icount` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then pulse `req_step` at cycle 10:
  - `load_imem`=1 at 11.
  - `exec_en`=`pc_inc`=1 at 12.
  - `busy` low at 13.
  - `icount`=1 (macro on).
- Pulse `req_fpga` and `req_step` in the same cycle: `load_fpga`=1 next cycle, then `exec_en`=1, and `pc_inc` never asserts.
- Pulse `req_run` with RUN_GAP=4: `exec_en` fires at start+2, +8, +14, …; a second `req_run` during GAP leaves `running`=0 with no further strobes.
- In run mode, raise `halt` during GAP: go to HALTED, `halted`=1, `running`=0; later `req_step`/`req_fpga` produce no strobes.
- Assert `reset` during LOADI: outputs zero immediately with no `exec_en`; a fresh `req_step` works normally.
- Macro on, CNT_W=4, 17 steps: `icount` reads 1 (wrap); with macro off `icount` stays 0.
